// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, FSM state encoding and opcode helpers
//
// Purpose: common definitions for the iterative carry-lookahead ALU.
// Contents: ALUop encodings, the IDLE/RUN/DONE state type, and opcode
// classification helpers used by both the slice and the top level.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_RSVD = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operations that go through the carry chain.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // Operations that compute a + ~b + 1.
  function automatic logic is_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/cla_slice_n.sv
// rtl/cla_slice_n.sv - combinational SLICE-bit carry-lookahead ALU slice
//
// Purpose: one SLICE-bit slice of the ALU with a fully expanded lookahead
// carry network (no ripple between bit positions inside the slice).
// Ports:
//   a, b     : slice operands (b is inverted internally for SUB/SLT)
//   alu_op   : operation code
//   c_in     : carry into bit 0 of the slice
//   r        : slice result bits
//   c        : carry into each bit position
//   g, p     : group generate / propagate of the slice
//   c_out    : carry out of the top bit
//   c_msb    : carry into the top bit (used for signed overflow)
module cla_slice_n
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       alu_op,
  input  logic             c_in,
  output logic [SLICE-1:0] r,
  output logic [SLICE-1:0] c,
  output logic             g,
  output logic             p,
  output logic             c_out,
  output logic             c_msb
);

  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] gi;
  logic [SLICE-1:0] pi;

  // Carry into bit n written as a flat sum of products:
  // c_n = g_{n-1} | p_{n-1}g_{n-2} | ... | p_{n-1}..p_0 c_in
  function automatic logic la_carry(input int n, input logic [SLICE-1:0] gv,
                                    input logic [SLICE-1:0] pv, input logic cin);
    logic acc;
    logic term;
    acc = cin;
    for (int k = 0; k < n; k++) acc = acc & pv[k];
    for (int j = 0; j < n; j++) begin
      term = gv[j];
      for (int k = j + 1; k < n; k++) term = term & pv[k];
      acc = acc | term;
    end
    return acc;
  endfunction

  always_comb begin
    bb = b ^ {SLICE{is_sub(alu_op)}};
    gi = a & bb;
    pi = a ^ bb;
    for (int i = 0; i < SLICE; i++) c[i] = la_carry(i, gi, pi, c_in);
    g     = la_carry(SLICE, gi, pi, 1'b0);
    p     = &pi;
    c_out = g | (p & c_in);
    c_msb = c[SLICE-1];

    case (alu_op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_ADD, ALU_SUB, ALU_SLT: r = pi ^ c;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/cla_alu_iter.sv
// rtl/cla_alu_iter.sv - multi-cycle ALU processing SLICE bits per cycle
//
// Purpose: WIDTH-bit ALU built around one shared SLICE-bit lookahead slice;
// an operation takes WIDTH/SLICE cycles with the inter-slice carry held in
// a register. Request and result use valid/ready handshakes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake; a, b, ALUop sampled on accept
//   out_valid, out_ready: result handshake; outputs held until taken
//   r                   : result
//   c_out, v, set, zero : carry out, signed overflow, SLT bit, r == 0
module cla_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             v,
  output logic             set,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
    $error("cla_alu_iter: WIDTH must be a positive multiple of SLICE");
  end

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_d;
  logic [NSLICE-1:0][SLICE-1:0] b_q, b_d;
  logic [NSLICE-1:0][SLICE-1:0] r_q, r_d;
  logic [2:0]      op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            v_q, v_d;
  logic            set_q, set_d;
  logic            zero_q, zero_d;

  logic [SLICE-1:0] sl_r;
  logic [SLICE-1:0] sl_c;
  logic             sl_g;
  logic             sl_p;
  logic             sl_c_out;
  logic             sl_c_msb;
  logic             ovf;

  cla_slice_n #(.SLICE(SLICE)) u_slice (
    .a      (a_q[idx_q]),
    .b      (b_q[idx_q]),
    .alu_op (op_q),
    .c_in   (carry_q),
    .r      (sl_r),
    .c      (sl_c),
    .g      (sl_g),
    .p      (sl_p),
    .c_out  (sl_c_out),
    .c_msb  (sl_c_msb)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    v_d         = v_q;
    set_d       = set_q;
    zero_d      = zero_q;
    ovf         = sl_c_msb ^ sl_c_out;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          op_d    = ALUop;
          idx_d   = '0;
          // +1 of the two's complement for a - b enters as the first carry
          carry_d = is_sub(ALUop);
          r_d     = '0;
          c_out_d = 1'b0;
          v_d     = 1'b0;
          set_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        r_d[idx_q] = sl_r;
        carry_d    = sl_c_out;
        if (idx_q == LAST_IDX) begin
          c_out_d = is_arith(op_q) & sl_c_out;
          v_d     = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) & ovf;
          // Only SUB/SLT run a - b through the chain, so set is defined for them alone
          set_d   = is_sub(op_q) & (sl_r[SLICE-1] ^ ovf);
          if (op_q == ALU_SLT) begin
            r_d       = '0;
            r_d[0][0] = set_d;
          end
          zero_d      = (r_d == '0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so that in_ready stays low through reset and the handshake cycle
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      op_q        <= ALU_AND;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      v_q         <= 1'b0;
      set_q       <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      v_q         <= v_d;
      set_q       <= set_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign set       = set_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_alu_iter.sv
// tb/tb_cla_alu_iter.sv - directed self-checking bench for cla_alu_iter
module tb_cla_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ordy, ir, ov, co, vv, st, zr;
  logic [31:0] a_in, b_in;
  logic [2:0]  op_in;
  logic [31:0] r0, r1;
  logic [7:0]  r2;
  int          n_vec, n_err;
  int          lat;

  always #5 clk = ~clk;

  cla_alu_iter #(.WIDTH(32), .SLICE(4)) u_w32s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in), .b(b_in), .ALUop(op_in), .out_valid(ov[0]), .out_ready(ordy[0]),
    .r(r0), .c_out(co[0]), .v(vv[0]), .set(st[0]), .zero(zr[0]));

  cla_alu_iter #(.WIDTH(32), .SLICE(32)) u_w32s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in), .b(b_in), .ALUop(op_in), .out_valid(ov[1]), .out_ready(ordy[1]),
    .r(r1), .c_out(co[1]), .v(vv[1]), .set(st[1]), .zero(zr[1]));

  cla_alu_iter #(.WIDTH(8), .SLICE(2)) u_w8s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_in[7:0]), .b(b_in[7:0]), .ALUop(op_in), .out_valid(ov[2]), .out_ready(ordy[2]),
    .r(r2), .c_out(co[2]), .v(vv[2]), .set(st[2]), .zero(zr[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_r(input int sel);
    case (sel)
      0:       return r0;
      1:       return r1;
      default: return {24'h0, r2};
    endcase
  endfunction

  task automatic consume(input string tag, input int sel);
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    chk({tag, ".out_valid_after"}, {63'h0, ov[sel]}, 64'd0);
    chk({tag, ".in_ready_after"}, {63'h0, ir[sel]}, 64'd1);
  endtask

  // Accept one op, count edges to out_valid, check result fields.
  task automatic op_check(input string tag, input int sel, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [2:0] op, input int exp_lat,
                          input logic [31:0] er, input logic ec, input logic ev,
                          input logic es, input logic ez, input logic take);
    chk({tag, ".in_ready"}, {63'h0, ir[sel]}, 64'd1);
    a_in = aa; b_in = bb; op_in = op; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while ((ov[sel] !== 1'b1) && (lat < 64));
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".r"}, {32'h0, rd_r(sel)}, {32'h0, er});
    chk({tag, ".c_out"}, {63'h0, co[sel]}, {63'h0, ec});
    chk({tag, ".v"}, {63'h0, vv[sel]}, {63'h0, ev});
    chk({tag, ".set"}, {63'h0, st[sel]}, {63'h0, es});
    chk({tag, ".zero"}, {63'h0, zr[sel]}, {63'h0, ez});
    if (take) consume(tag, sel);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; iv = '0; ordy = '0; a_in = '0; b_in = '0; op_in = ALU_AND;

    repeat (3) @(posedge clk); #1;
    chk("rst.in_ready", {61'h0, ir}, 64'd0);
    chk("rst.out_valid", {61'h0, ov}, 64'd0);
    chk("rst.r", {32'h0, r0}, 64'd0);
    chk("rst.zero", {61'h0, zr}, 64'h7);
    chk("rst.flags", {55'h0, co, vv, st}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.in_ready", {61'h0, ir}, 64'h7);

    op_check("add_ovf", 0, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 8, 32'h8000_0000, 0, 1, 0, 0, 1);
    op_check("sub_eq", 0, 32'd5, 32'd5, ALU_SUB, 8, 32'h0, 1, 0, 0, 1, 1);
    op_check("add_wrap", 0, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 8, 32'h0, 1, 0, 0, 1, 1);
    op_check("sub_neg", 0, 32'd3, 32'd5, ALU_SUB, 8, 32'hFFFF_FFFE, 0, 0, 1, 0, 1);
    op_check("slt_true", 0, 32'hFFFF_FFFF, 32'h1, ALU_SLT, 8, 32'h1, 1, 0, 1, 0, 1);
    op_check("slt_ovf", 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, ALU_SLT, 8, 32'h0, 0, 0, 0, 1, 1);
    op_check("xor", 0, 32'hFFFF_0000, 32'h0F0F_0F0F, ALU_XOR, 8, 32'hF0F0_0F0F, 0, 0, 0, 0, 1);
    op_check("nor", 0, 32'h0, 32'h0, ALU_NOR, 8, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    op_check("or", 0, 32'h1200_0034, 32'h0050_6000, ALU_OR, 8, 32'h1250_6034, 0, 0, 0, 0, 1);
    op_check("rsvd", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_RSVD, 8, 32'h0, 0, 0, 0, 1, 1);

    // Back-pressure: result held, requests ignored while DONE.
    op_check("bp", 0, 32'd1, 32'd2, ALU_ADD, 8, 32'd3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom; b_in = $urandom; op_in = ALU_SUB; iv[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp.hold_r", {32'h0, r0}, 64'd3);
      chk("bp.hold_valid", {63'h0, ov[0]}, 64'd1);
      chk("bp.hold_in_ready", {63'h0, ir[0]}, 64'd0);
      chk("bp.hold_flags", {60'h0, co[0], vv[0], st[0], zr[0]}, 64'd0);
    end
    iv[0] = 1'b0;
    consume("bp", 0);
    @(posedge clk); #1;
    chk("bp.no_accept", {63'h0, ov[0]}, 64'd0);

    // Reset in the middle of RUN.
    a_in = 32'h1234_5678; b_in = 32'h1111_1111; op_in = ALU_ADD; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid.partial_r", {32'h0, r0}, 64'h789);
    chk("mid.valid_pre", {63'h0, ov[0]}, 64'd0);
    rst_n = 1'b0; #1;
    chk("mid.valid", {63'h0, ov[0]}, 64'd0);
    chk("mid.r", {32'h0, r0}, 64'd0);
    chk("mid.zero", {63'h0, zr[0]}, 64'd1);
    chk("mid.in_ready", {63'h0, ir[0]}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_check("post_rst_and", 0, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 8, 32'hF000_F000, 0, 0, 0, 0, 1);

    // Other geometries.
    op_check("s32_add", 1, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 1, 32'h8000_0000, 0, 1, 0, 0, 1);
    op_check("s32_sub", 1, 32'd3, 32'd5, ALU_SUB, 1, 32'hFFFF_FFFE, 0, 0, 1, 0, 1);
    op_check("w8_add", 2, 32'h7F, 32'h01, ALU_ADD, 4, 32'h80, 0, 1, 0, 0, 1);
    op_check("w8_wrap", 2, 32'hFF, 32'h01, ALU_ADD, 4, 32'h00, 1, 0, 0, 1, 1);
    op_check("w8_slt", 2, 32'h80, 32'h01, ALU_SLT, 4, 32'h01, 1, 0, 1, 0, 1);
    op_check("w8_rsvd", 2, 32'h5A, 32'hA5, ALU_RSVD, 4, 32'h00, 0, 0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
